fifo_umbrales: RTL and testbench

- Synchronous FIFO that sits directly downstream of the flow-control FSM.
- Stores data words and compares its occupancy against the low/high thresholds (umbrales) driven by the FSM.
- Returns empty, almost-full/almost-empty and sticky error status, which feed the FSM's empties/errors inputs.
- One instance is used per main FIFO, VC0, VC1, D0 and D1.

---
 rtl/fifo_umbrales.sv | 118 +++++++++++
 tb/tb_fifo_umbrales.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_umbrales.sv
// 16-entry synchronous FIFO with occupancy count, empty/full flags and
// almost-empty/almost-full flags compared against thresholds registered from the FSM.
module fifo_umbrales #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic [CNT_WIDTH-1:0]  umbral_low,
    input  logic [CNT_WIDTH-1:0]  umbral_high,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  error
);

    localparam int                   DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_DEPTH  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_error;
    logic [CNT_WIDTH-1:0]  r_umbral_low_q;
    logic [CNT_WIDTH-1:0]  r_umbral_high_q;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_almost_empty;
    logic w_almost_full;

    // Status flags and accept decisions, all from pre-edge state
    always_comb begin
        w_empty        = 1'b0;
        w_full         = 1'b0;
        w_almost_full  = 1'b0;
        w_empty        = (r_count == CNT_ZERO);
        w_full         = (r_count == CNT_DEPTH);
        w_push_ok      = push & ~w_full;
        w_pop_ok       = pop & ~w_empty;
        w_almost_empty = (r_count <= r_umbral_low_q);
        // A zero high threshold disables the flag; one above DEPTH can never be reached
        if (r_umbral_high_q != CNT_ZERO) begin
            w_almost_full = (r_count >= r_umbral_high_q);
        end else begin
            w_almost_full = 1'b0;
        end
    end

    // Storage array: written on accepted push, never reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, read data, sticky error and threshold capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr        <= PTR_ZERO;
            r_rd_ptr        <= PTR_ZERO;
            r_count         <= CNT_ZERO;
            r_data_out      <= {DATA_WIDTH{1'b0}};
            r_valid_out     <= 1'b0;
            r_error         <= 1'b0;
            r_umbral_low_q  <= CNT_ZERO;
            r_umbral_high_q <= CNT_ZERO;
        end else begin
            r_umbral_low_q  <= umbral_low;
            r_umbral_high_q <= umbral_high;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_data_out  <= r_mem[r_rd_ptr];
                r_valid_out <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + PTR_ONE;
            end else begin
                r_valid_out <= 1'b0;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if ((push && w_full) || (pop && w_empty)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = w_almost_empty;
    assign almost_full  = w_almost_full;
    assign error        = r_error;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Scoreboard bench for fifo_umbrales: a queue-based reference model predicts status
// every cycle and queues expected read words that a separate monitor consumes.
module tb_fifo_umbrales;

    logic       clk;
    logic       reset;
    logic [5:0] data_in;
    logic       push;
    logic       pop;
    logic [4:0] umbral_low;
    logic [4:0] umbral_high;
    logic [5:0] data_out;
    logic       valid_out;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       error;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [5:0] mq[$];
    logic [5:0] exp_q[$];
    logic [5:0] m_dout;
    logic       m_valid;
    logic       m_err;
    int         m_low;
    int         m_high;

    fifo_umbrales dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .umbral_low   (umbral_low),
        .umbral_high  (umbral_high),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word the DUT presents must be the next one the model predicted
    always @(negedge clk) begin
        if (reset && valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%0d expected=none", data_out);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    failures++;
                    $display("FAIL sb_data actual=%0d expected=%0d at %0t", data_out, e, $time);
                end
            end
        end
    end

    task automatic check_status();
        int n;
        n = mq.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == 16));
        chk("almost_empty", int'(almost_empty), int'(n <= m_low));
        chk("almost_full", int'(almost_full), int'((m_high != 0) && (n >= m_high)));
        chk("error", int'(error), int'(m_err));
        chk("valid_out", int'(valid_out), int'(m_valid));
        chk("data_out", int'(data_out), int'(m_dout));
    endtask

    // One clock: predict from pre-edge model state, clock the DUT, compare after the edge
    task automatic step(input logic p, input logic q, input logic [5:0] d);
        bit full_m, empty_m;
        push    = p;
        pop     = q;
        data_in = d;
        full_m  = (mq.size() == 16);
        empty_m = (mq.size() == 0);
        if ((p && full_m) || (q && empty_m)) m_err = 1'b1;
        if (q && !empty_m) begin
            m_dout  = mq.pop_front();
            m_valid = 1'b1;
            exp_q.push_back(m_dout);
        end else begin
            m_valid = 1'b0;
        end
        if (p && !full_m) mq.push_back(d);
        m_low  = int'(umbral_low);
        m_high = int'(umbral_high);
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'(data_out), 0);
        mq.delete();
        exp_q.delete();
        m_dout  = 6'h00;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_low   = 0;
        m_high  = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = 6'h00;
        umbral_low  = 5'd0;
        umbral_high = 5'd0;
        #12;
        do_reset();

        // reset mid-stream after 5 pushes
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(i + 9));
        do_reset();

        // thresholds 3/6, push 1..7 then pop all back in order
        umbral_low  = 5'd3;
        umbral_high = 5'd6;
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 6'(i));
            chk("t2_almost_empty", int'(almost_empty), int'(i <= 3));
            chk("t2_almost_full", int'(almost_full), int'(i >= 6));
        end
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b1, 6'h00);
            chk("t2_pop_data", int'(data_out), i);
        end
        step(1'b0, 1'b0, 6'h00);

        // fill, then overflow push of 'h3F; error sticks until reset
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 6'(i + 16));
        step(1'b1, 1'b0, 6'h3F);
        chk("t3_full", int'(full), 1);
        chk("t3_error", int'(error), 1);
        step(1'b1, 1'b1, 6'h3F);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b0, 6'h00);
        chk("t3_error_sticky", int'(error), 1);
        do_reset();

        // underflow: data_out keeps the last popped word
        step(1'b1, 1'b0, 6'h15);
        step(1'b0, 1'b1, 6'h00);
        step(1'b0, 1'b1, 6'h00);
        chk("t4_error", int'(error), 1);
        chk("t4_valid", int'(valid_out), 0);
        chk("t4_hold", int'(data_out), 6'h15);
        step(1'b1, 1'b1, 6'h21);
        do_reset();

        // count 8 with simultaneous push/pop across the pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'($urandom_range(0, 63)));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, (i == 0) ? 6'h2A : 6'(i));
            chk("t5_count", int'(count), 8);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00);

        // threshold change takes effect one cycle later
        do_reset();
        umbral_high = 5'd8;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(i));
        chk("t6_af_before", int'(almost_full), 0);
        umbral_high = 5'd4;
        #1;
        check_status();
        chk("t6_af_same_cycle", int'(almost_full), 0);
        step(1'b0, 1'b0, 6'h00);
        chk("t6_af_after", int'(almost_full), 1);

        // randomized traffic with random thresholds, including out-of-range ones
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                umbral_low  = 5'($urandom_range(0, 20));
                umbral_high = 5'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else if (i < 300) begin
                step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, 6'($urandom_range(0, 63)));
            end else begin
                step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, 6'($urandom_range(0, 63)));
            end
        end

        step(1'b0, 1'b0, 6'h00);
        @(negedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
